// File: rtl/lfsr_gen.sv
// Galois right-shift LFSR with step enable, seed load, all-zero lock-up protection,
// period-wrap pulse and step counter.
module lfsr_gen #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'h0001,
    parameter int unsigned      CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] q,
    output logic             bit_out,
    output logic             wrap,
    output logic [CNT_W-1:0] step_cnt,
    output logic             lockup
);

    logic [WIDTH-1:0] ref_q;
    logic [WIDTH-1:0] lfsr_nxt;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] ref_d;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap_d;
    logic             lockup_d;

    // One Galois step: shift right, fold the taps in when the dropped bit is set.
    assign lfsr_nxt = (q >> 1) ^ (q[0] ? TAPS : '0);
    assign bit_out  = q[0];

    // Next-state selection: load > en > hold.
    always_comb begin
        q_d      = q;
        ref_d    = ref_q;
        cnt_d    = step_cnt;
        wrap_d   = 1'b0;
        lockup_d = lockup;
        if (load) begin
            cnt_d = '0;
            if (seed != '0) begin
                q_d      = seed;
                ref_d    = seed;
                lockup_d = 1'b0;
            end else begin
                // An all-zero seed would freeze the register; substitute the reset seed.
                q_d      = SEED;
                ref_d    = SEED;
                lockup_d = 1'b1;
            end
        end else if (en) begin
            q_d = lfsr_nxt;
            if (lfsr_nxt == ref_q) begin
                wrap_d = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = step_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q        <= SEED;
            ref_q    <= SEED;
            step_cnt <= '0;
            wrap     <= 1'b0;
            lockup   <= 1'b0;
        end else begin
            q        <= q_d;
            ref_q    <= ref_d;
            step_cnt <= cnt_d;
            wrap     <= wrap_d;
            lockup   <= lockup_d;
        end
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: directed sequences, randomized load/en traffic
// against a behavioural model, full-period wrap and asynchronous reset.
module tb_lfsr_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        en, load;
    logic [15:0] seed;
    logic [15:0] q;
    logic        bit_out, wrap, lockup;
    logic [15:0] step_cnt;

    logic        en4, load4;
    logic [3:0]  seed4, q4, cnt4;
    logic        bit4, wrap4, lock4;

    int errors = 0;
    int checks = 0;

    // Behavioural model of the default instance
    int m_q, m_ref, m_cnt;
    bit m_wrap, m_lock;

    always #5 clk = ~clk;

    lfsr_gen dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .seed(seed),
        .q(q), .bit_out(bit_out), .wrap(wrap), .step_cnt(step_cnt), .lockup(lockup)
    );

    lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .en(en4), .load(load4), .seed(seed4),
        .q(q4), .bit_out(bit4), .wrap(wrap4), .step_cnt(cnt4), .lockup(lock4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Polynomial step x^16+x^14+x^13+x^11+1 on a plain integer
    function automatic int poly_step(input int s);
        return (s >> 1) ^ (((s & 1) != 0) ? 32'hB400 : 32'h0);
    endfunction

    task automatic model_reset();
        m_q = 1; m_ref = 1; m_cnt = 0; m_wrap = 0; m_lock = 0;
    endtask

    task automatic model_edge(input bit e, input bit l, input int s);
        if (l) begin
            m_cnt = 0; m_wrap = 0;
            if (s != 0) begin m_q = s; m_ref = s; m_lock = 0; end
            else        begin m_q = 1; m_ref = 1; m_lock = 1; end
        end else if (e) begin
            m_q = poly_step(m_q);
            if (m_q == m_ref) begin m_wrap = 1; m_cnt = 0; end
            else begin m_wrap = 0; m_cnt = (m_cnt + 1) % 65536; end
        end else begin
            m_wrap = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(en, load, int'(seed));
        #1;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_q"}, 32'(q), 32'(m_q));
        check({tag, "_bit"}, 32'(bit_out), 32'(m_q & 1));
        check({tag, "_cnt"}, 32'(step_cnt), 32'(m_cnt));
        check({tag, "_wrap"}, 32'(wrap), 32'(m_wrap));
        check({tag, "_lock"}, 32'(lockup), 32'(m_lock));
    endtask

    initial begin
        logic [15:0] seq16 [13];
        logic [3:0]  seq4  [16];
        logic [15:0] saved_q;
        seq16 = '{16'h0001, 16'hB400, 16'h5A00, 16'h2D00, 16'h1680, 16'h0B40, 16'h05A0,
                  16'h02D0, 16'h0168, 16'h00B4, 16'h005A, 16'h002D, 16'hB416};
        seq4  = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                  4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};

        reset = 1'b0; en = 1'b0; load = 1'b0; seed = '0;
        en4 = 1'b0; load4 = 1'b0; seed4 = '0;
        model_reset();
        #12;
        check_all("rst");
        check("rst_q4", 32'(q4), 32'h1);
        @(negedge clk);
        reset = 1'b1;

        // Default sequence from reset
        en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check("seq_q", 32'(q), 32'(seq16[i]));
            check("seq_cnt", 32'(step_cnt), 32'(i));
            check_all("seq");
        end

        // 4-bit instance full period while the wide one holds
        en = 1'b0; en4 = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("w4_q", 32'(q4), 32'(seq4[i]));
            check("w4_bit", 32'(bit4), 32'(seq4[i] & 4'h1));
            check("w4_wrap", 32'(wrap4), 32'(i == 15));
            check("w4_cnt", 32'(cnt4), (i == 15) ? 32'd0 : 32'(i));
        end
        en4 = 1'b0;
        check_all("hold16");

        // Zero-seed load with en asserted
        load = 1'b1; seed = 16'h0000; en = 1'b1;
        tick();
        check("zload_q", 32'(q), 32'h0001);
        check("zload_lock", 32'(lockup), 32'h1);
        check("zload_cnt", 32'(step_cnt), 32'h0);
        seed = 16'hACE1; en = 1'b0;
        tick();
        check("ace_q", 32'(q), 32'hACE1);
        check("ace_lock", 32'(lockup), 32'h0);
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(); check_all("ace_step"); end

        // load wins over en; then freeze with en low
        load = 1'b1; seed = 16'h1234;
        tick();
        check("le_q", 32'(q), 32'h1234);
        check("le_cnt", 32'(step_cnt), 32'h0);
        load = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check_all("le_step");
        saved_q = q;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("frz_q", 32'(q), 32'(saved_q));
            check("frz_cnt", 32'(step_cnt), 32'd3);
            check("frz_wrap", 32'(wrap), 32'h0);
        end

        // Randomized load/en traffic against the model
        for (int i = 0; i < 1500; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            load = ($urandom_range(0, 15) == 0);
            seed = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            tick();
            check_all("rnd");
        end

        // Asynchronous reset between edges
        load = 1'b1; en = 1'b0; seed = 16'hACE1;
        tick();
        load = 1'b0; en = 1'b1;
        tick(); tick();
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("arst_seq", 32'(q), 32'(seq16[i]));
            check_all("arst_step");
        end

        // Full maximal-length period from 0001
        load = 1'b1; seed = 16'h0001;
        tick();
        load = 1'b0; en = 1'b1;
        for (int i = 1; i <= 65535; i++) begin
            tick();
            check("per_q", 32'(q), 32'(m_q));
            check("per_wrap", 32'(wrap), 32'(i == 65535));
            if (i == 65534) check("per_cnt_max", 32'(step_cnt), 32'd65534);
        end
        check("per_end_q", 32'(q), 32'h0001);
        check("per_end_cnt", 32'(step_cnt), 32'h0);
        tick();
        check("per_after_wrap", 32'(wrap), 32'h0);
        check("per_after_cnt", 32'(step_cnt), 32'h1);
        check("per_after_q", 32'(q), 32'hB400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
